// File: rtl/urng_pkg.sv
// Shared constants for the combined five-component Tausworthe generator
// (lfsr258): per-component shift/mask parameters, minimum seeds, default seeds.
package urng_pkg;

  localparam int unsigned N_COMP = 5;

  // Component parameters, indexed 1..5: shift-a (q), shift-b (k-s), mask, shift-c (s).
  localparam int unsigned TAUS_Q  [1:5] = '{1, 24, 3, 5, 3};
  localparam int unsigned TAUS_KS [1:5] = '{53, 50, 23, 24, 33};
  localparam int unsigned TAUS_S  [1:5] = '{10, 5, 29, 23, 8};
  localparam logic [63:0] TAUS_MASK [1:5] = '{
    64'hFFFF_FFFF_FFFF_FFFE,
    64'hFFFF_FFFF_FFFF_FE00,
    64'hFFFF_FFFF_FFFF_F000,
    64'hFFFF_FFFF_FFFE_0000,
    64'hFFFF_FFFF_FF80_0000
  };

  // A seed must be strictly greater than its minimum, or the component can lock at zero.
  localparam logic [63:0] SEED1_MIN = 64'd1;
  localparam logic [63:0] SEED2_MIN = 64'd511;
  localparam logic [63:0] SEED3_MIN = 64'd4095;
  localparam logic [63:0] SEED4_MIN = 64'd131071;
  localparam logic [63:0] SEED5_MIN = 64'd8388607;

  localparam logic [63:0] DEF_SEED1 = 64'd123456789;
  localparam logic [63:0] DEF_SEED2 = 64'd362436069;
  localparam logic [63:0] DEF_SEED3 = 64'd521288629;
  localparam logic [63:0] DEF_SEED4 = 64'd88675123;
  localparam logic [63:0] DEF_SEED5 = 64'd5783321;

  // The default SEED5 is below its minimum; it is silently swapped for this value.
  localparam logic [63:0] SEED5_SUB = 64'd987654321;

  // Effective SEED5 after the documented default substitution.
  function automatic logic [63:0] fix_seed5(input logic [63:0] s);
    if (s <= SEED5_MIN && s == DEF_SEED5) begin
      return SEED5_SUB;
    end
    return s;
  endfunction

endpackage

// File: rtl/taus_step.sv
// One combinational step of a single Tausworthe component.
module taus_step
  import urng_pkg::*;
#(
  parameter int unsigned Q    = 1,
  parameter int unsigned KS   = 53,
  parameter int unsigned S    = 10,
  parameter logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFFE
) (
  input  logic [63:0] z,
  output logic [63:0] z_next
);

  logic [63:0] feedback;

  // Feedback bits shifted down, merged with the masked state shifted up.
  always_comb begin
    feedback = ((z << Q) ^ z) >> KS;
    z_next   = ((z & MASK) << S) ^ feedback;
  end

endmodule

// File: rtl/urng64.sv
// 64-bit uniform random number generator (L'Ecuyer lfsr258).
// One new word per enabled clock; valid flags the cycle after each step.
module urng64
  import urng_pkg::*;
#(
  parameter logic [63:0] SEED1 = DEF_SEED1,
  parameter logic [63:0] SEED2 = DEF_SEED2,
  parameter logic [63:0] SEED3 = DEF_SEED3,
  parameter logic [63:0] SEED4 = DEF_SEED4,
  parameter logic [63:0] SEED5 = DEF_SEED5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [63:0] data_out,
  output logic        valid
);

  localparam logic [63:0] SEED5_EFF = fix_seed5(SEED5);
  localparam logic [63:0] SEEDS [1:5] = '{SEED1, SEED2, SEED3, SEED4, SEED5_EFF};

  // Illegal seeds are rejected at elaboration.
  if (SEED1 <= SEED1_MIN) begin : g_bad_seed1
    $fatal(1, "urng64: SEED1 must be greater than 1");
  end
  if (SEED2 <= SEED2_MIN) begin : g_bad_seed2
    $fatal(1, "urng64: SEED2 must be greater than 511");
  end
  if (SEED3 <= SEED3_MIN) begin : g_bad_seed3
    $fatal(1, "urng64: SEED3 must be greater than 4095");
  end
  if (SEED4 <= SEED4_MIN) begin : g_bad_seed4
    $fatal(1, "urng64: SEED4 must be greater than 131071");
  end
  if (SEED5_EFF <= SEED5_MIN) begin : g_bad_seed5
    $fatal(1, "urng64: SEED5 must be greater than 8388607");
  end

  logic [63:0] z      [1:5];
  logic [63:0] z_next [1:5];
  logic [63:0] word_next;

  for (genvar g = 1; g <= 5; g++) begin : g_comp
    taus_step #(
      .Q    (TAUS_Q[g]),
      .KS   (TAUS_KS[g]),
      .S    (TAUS_S[g]),
      .MASK (TAUS_MASK[g])
    ) u_step (
      .z      (z[g]),
      .z_next (z_next[g])
    );
  end

  // Output word is the XOR of all five updated component states.
  always_comb begin
    word_next = '0;
    for (int unsigned i = 1; i <= N_COMP; i++) begin
      word_next = word_next ^ z_next[i];
    end
  end

  // State, output and valid registers; reset overrides enable.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned i = 1; i <= N_COMP; i++) begin
        z[i] <= SEEDS[i];
      end
      data_out <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      for (int unsigned i = 1; i <= N_COMP; i++) begin
        z[i] <= z_next[i];
      end
      data_out <= word_next;
      valid    <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_urng64.sv
// Self-checking bench for urng64: directed vector table plus golden-model sequences.
module tb_urng64;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [63:0] data_out;
  logic        valid;
  logic [63:0] data_out_c;
  logic        valid_c;

  int checks;
  int failures;

  urng64 dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .data_out (data_out),
    .valid    (valid)
  );

  urng64 #(
    .SEED1 (64'd3),
    .SEED2 (64'd600),
    .SEED3 (64'd5000),
    .SEED4 (64'd200000),
    .SEED5 (64'd9000000)
  ) dut_c (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .data_out (data_out_c),
    .valid    (valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference lfsr258 in plain software form.
  logic [63:0] gold  [0:999];
  logic [63:0] cgold [0:99];

  task automatic model_run(input logic [63:0] s1_i, s2_i, s3_i, s4_i, s5_i,
                           input int n, output logic [63:0] out [0:999]);
    logic [63:0] s1, s2, s3, s4, s5, b;
    s1 = s1_i; s2 = s2_i; s3 = s3_i; s4 = s4_i; s5 = s5_i;
    for (int i = 0; i < n; i++) begin
      b  = ((s1 << 1) ^ s1) >> 53;
      s1 = ((s1 & 64'hFFFFFFFFFFFFFFFE) << 10) ^ b;
      b  = ((s2 << 24) ^ s2) >> 50;
      s2 = ((s2 & 64'hFFFFFFFFFFFFFE00) << 5) ^ b;
      b  = ((s3 << 3) ^ s3) >> 23;
      s3 = ((s3 & 64'hFFFFFFFFFFFFF000) << 29) ^ b;
      b  = ((s4 << 5) ^ s4) >> 24;
      s4 = ((s4 & 64'hFFFFFFFFFFFE0000) << 23) ^ b;
      b  = ((s5 << 3) ^ s5) >> 33;
      s5 = ((s5 & 64'hFFFFFFFFFF800000) << 8) ^ b;
      out[i] = s1 ^ s2 ^ s3 ^ s4 ^ s5;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply inputs, take one edge, sample #1 later.
  task automatic cycle(input logic r, input logic e);
    rstn = r;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r;
    logic e;
    logic exp_valid;
    int   exp_idx;   // -1: data_out must be zero, else index into gold
  } vec_t;

  vec_t vecs [0:13];
  logic [63:0] tmp [0:999];
  int bitcnt [0:63];
  int lo_cnt, mid_cnt;
  logic [63:0] w;
  localparam logic [63:0] THR_LO  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] THR_HI  = 64'h7FFF_FFFF_FFFF_FFFF + 64'h4000_0000_0000_0000;

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b1;
    en       = 1'b0;

    model_run(64'd123456789, 64'd362436069, 64'd521288629, 64'd88675123,
              64'd987654321, 1000, tmp);
    for (int i = 0; i < 1000; i++) gold[i] = tmp[i];
    model_run(64'd3, 64'd600, 64'd5000, 64'd200000, 64'd9000000, 100, tmp);
    for (int i = 0; i < 100; i++) cgold[i] = tmp[i];

    // Reset/idle, reset overriding enable, then gapped enable 1,0,0,1,1,0,1.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, -1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, -1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, -1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, -1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, -1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, -1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, -1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 3};

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].r, vecs[i].e);
      chk($sformatf("vec%0d_valid", i), {63'd0, valid}, {63'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), data_out,
          (vecs[i].exp_idx < 0) ? 64'd0 : gold[vecs[i].exp_idx]);
    end

    // Golden run: 1000 words from reset; custom-seed instance checked on the first 100.
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, 1'b1);
      chk($sformatf("gold%0d_valid", i), {63'd0, valid}, 64'd1);
      chk($sformatf("gold%0d_data", i), data_out, gold[i]);
      if (i < 100) begin
        chk($sformatf("cust%0d_data", i), data_out_c, cgold[i]);
      end
    end

    // Mid-stream reset after 37 words, with en still high during reset.
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 37; i++) begin
      cycle(1'b0, 1'b1);
      chk($sformatf("mid%0d_data", i), data_out, gold[i]);
    end
    cycle(1'b1, 1'b1);
    chk("midrst_valid", {63'd0, valid}, 64'd0);
    chk("midrst_data", data_out, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1);
      chk($sformatf("resume%0d_data", i), data_out, gold[i]);
    end

    // Distribution over 2^16 words.
    for (int b = 0; b < 64; b++) bitcnt[b] = 0;
    lo_cnt  = 0;
    mid_cnt = 0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      cycle(1'b0, 1'b1);
      w = data_out;
      for (int b = 0; b < 64; b++) bitcnt[b] += int'(w[b]);
      if (w < THR_LO) lo_cnt++;
      else if (w < THR_HI) mid_cnt++;
    end
    for (int b = 0; b < 64; b++) begin
      chk($sformatf("bit%0d_freq_ok", b),
          {63'd0, (bitcnt[b] >= 32113 && bitcnt[b] <= 33423)}, 64'd1);
      if (!(bitcnt[b] >= 32113 && bitcnt[b] <= 33423))
        $display("  bit %0d count %0d", b, bitcnt[b]);
    end
    chk("below_half_count_ok", {63'd0, (lo_cnt >= 32113 && lo_cnt <= 33423)}, 64'd1);
    chk("quarter_band_count_ok", {63'd0, (mid_cnt >= 15729 && mid_cnt <= 17039)}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
